// File: rtl/change_dispenser.sv
// change_dispenser: turns a latched vend decision into timed, one-at-a-time gruel and
// shilling actuator pulses, with busy/done status and a live remaining-change count.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// Idle     | waiting for a synchronized rising edge of vend_req
// GruelOn  | gruel dispenser driven for PULSE_CYCLES
// GruelGap | mandatory off-time after the gruel pulse
// CoinOn   | shilling ejector driven for PULSE_CYCLES
// CoinGap  | mandatory off-time after a coin pulse
// Finish   | single-cycle completion, done strobe
module change_dispenser #(
  parameter int PULSE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES   = 12_500_000
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic       vend_req,
  input  logic       gruel_req,
  input  logic [2:0] change_count,
  output logic       gruel_pulse,
  output logic       coin_pulse,
  output logic       busy,
  output logic       done,
  output logic [2:0] shillings_left
);

  localparam int MaxCycles = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad   = CntW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    Idle     = 3'd0,
    GruelOn  = 3'd1,
    GruelGap = 3'd2,
    CoinOn   = 3'd3,
    CoinGap  = 3'd4,
    Finish   = 3'd5
  } stateT;

  stateT           state;
  stateT           nextState;
  logic [CntW-1:0] phaseCnt;
  logic [2:0]      coinsLeft;
  logic            syncS1;
  logic            syncS2;
  logic            syncS3;
  logic [1:0]      vldPipe;
  logic            armed;
  logic            startEvt;
  logic            phaseEnd;

  // armed only sets once the synchronizer has carried a real low sample of vend_req,
  // so a request already high when reset releases is not mistaken for a new edge.
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      syncS1  <= 1'b0;
      syncS2  <= 1'b0;
      syncS3  <= 1'b0;
      vldPipe <= 2'b00;
      armed   <= 1'b0;
    end else begin
      syncS1  <= vend_req;
      syncS2  <= syncS1;
      syncS3  <= syncS2;
      vldPipe <= {vldPipe[0], 1'b1};
      if (vldPipe[1] && !syncS2) begin
        armed <= 1'b1;
      end
    end
  end

  assign startEvt = syncS2 && !syncS3 && armed;
  assign phaseEnd = (phaseCnt == '0);

  always_comb begin
    nextState = state;
    case (state)
      Idle: begin
        if (startEvt) begin
          if (gruel_req) begin
            nextState = GruelOn;
          end else if (change_count != 3'd0) begin
            nextState = CoinOn;
          end else begin
            nextState = Finish;
          end
        end
      end
      GruelOn: begin
        if (phaseEnd) nextState = GruelGap;
      end
      GruelGap: begin
        if (phaseEnd) nextState = (coinsLeft != 3'd0) ? CoinOn : Finish;
      end
      CoinOn: begin
        if (phaseEnd) nextState = CoinGap;
      end
      CoinGap: begin
        if (phaseEnd) nextState = (coinsLeft != 3'd0) ? CoinOn : Finish;
      end
      Finish: begin
        nextState = Idle;
      end
      default: begin
        nextState = Idle;
      end
    endcase
  end

  // There are no self-transitions, so every state change is a fresh entry that reloads the timer.
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      state     <= Idle;
      phaseCnt  <= '0;
      coinsLeft <= 3'd0;
    end else begin
      state <= nextState;
      if (nextState != state) begin
        case (nextState)
          GruelOn, CoinOn:   phaseCnt <= PulseLoad;
          GruelGap, CoinGap: phaseCnt <= GapLoad;
          default:           phaseCnt <= '0;
        endcase
      end else if (!phaseEnd) begin
        phaseCnt <= phaseCnt - 1'b1;
      end

      if (state == Idle && startEvt) begin
        coinsLeft <= change_count;
      end else if (state == CoinOn && phaseEnd && coinsLeft != 3'd0) begin
        coinsLeft <= coinsLeft - 3'd1;
      end
    end
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      gruel_pulse    <= 1'b0;
      coin_pulse     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      shillings_left <= 3'd0;
    end else begin
      gruel_pulse    <= (state == GruelOn);
      coin_pulse     <= (state == CoinOn);
      busy           <= (state != Idle);
      done           <= (state == Finish);
      shillings_left <= coinsLeft;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: expected pulses are queued when a vend is driven
// and checked by a pulse monitor as the actuators fall; sequence timing checked inline.
module tb_change_dispenser;

  localparam int PULSE = 4;
  localparam int GAP   = 2;

  typedef struct {
    bit coin;
    int len;
    int shl;
  } pulseT;

  logic       clk50;
  logic       reset;
  logic       vend_req;
  logic       gruel_req;
  logic [2:0] change_count;
  logic       gruel_pulse;
  logic       coin_pulse;
  logic       busy;
  logic       done;
  logic [2:0] shillings_left;

  int    nCmp = 0;
  int    nErr = 0;
  pulseT sbQ[$];

  change_dispenser #(.PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP)) dut (
    .clk50(clk50),
    .reset(reset),
    .vend_req(vend_req),
    .gruel_req(gruel_req),
    .change_count(change_count),
    .gruel_pulse(gruel_pulse),
    .coin_pulse(coin_pulse),
    .busy(busy),
    .done(done),
    .shillings_left(shillings_left)
  );

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse monitor: measures each actuator pulse and the gap before the next one.
  logic  prevOn;
  int    runLen;
  int    gapLen;
  bit    inGap;
  bit    kindAtRise;
  int    shlAtRise;
  pulseT expP;

  always @(negedge clk50) begin
    if (!reset) begin
      prevOn = 1'b0;
      runLen = 0;
      gapLen = 0;
      inGap  = 1'b0;
    end else begin
      if ((gruel_pulse || coin_pulse) && !prevOn) begin
        chk("oneActuator", {31'd0, gruel_pulse && coin_pulse}, 0);
        if (inGap) chk("gapLen", gapLen, GAP);
        inGap      = 1'b0;
        runLen     = 1;
        kindAtRise = coin_pulse;
        shlAtRise  = int'(shillings_left);
      end else if (gruel_pulse || coin_pulse) begin
        runLen++;
      end else if (prevOn) begin
        chk("pulseExpected", {31'd0, sbQ.size() != 0}, 1);
        if (sbQ.size() != 0) begin
          expP = sbQ.pop_front();
          chk("pulseKind", {31'd0, kindAtRise}, {31'd0, expP.coin});
          chk("pulseLen", runLen, expP.len);
          chk("shlDuringPulse", shlAtRise, expP.shl);
        end
        inGap  = 1'b1;
        gapLen = 1;
      end else if (inGap) begin
        if (busy) gapLen++;
        else inGap = 1'b0;
      end
      prevOn = gruel_pulse || coin_pulse;
    end
  end

  task automatic runSeq(input bit g, input logic [2:0] n, input bit poke);
    int  k;
    int  lat;
    int  busyLen;
    int  doneCnt;
    bit  doneLast;
    bit  sawBusy;
    k = int'(g) + int'(n);
    if (g) sbQ.push_back('{1'b0, PULSE, int'(n)});
    for (int i = 0; i < int'(n); i++) sbQ.push_back('{1'b1, PULSE, int'(n) - i});
    @(negedge clk50);
    gruel_req    = g;
    change_count = n;
    vend_req     = 1'b1;
    lat = 0;
    do begin
      @(negedge clk50);
      lat++;
    end while (!busy && lat < 12);
    chk("startLatency", lat, 4);
    // scramble the inputs: they must only matter in the start cycle
    gruel_req    = ~g;
    change_count = ~n;
    busyLen  = 0;
    doneCnt  = 0;
    doneLast = 1'b0;
    while (busy && busyLen < 200) begin
      busyLen++;
      doneLast = done;
      if (done) doneCnt++;
      if (poke && busyLen == 5) vend_req = 1'b0;
      if (poke && busyLen == 8) begin
        vend_req     = 1'b1;
        change_count = 3'd5;
      end
      @(negedge clk50);
    end
    chk("busyLen", busyLen, k * (PULSE + GAP) + 1);
    chk("doneCount", doneCnt, 1);
    chk("doneInLastBusy", {31'd0, doneLast}, 1);
    chk("doneAfter", {31'd0, done}, 0);
    chk("shlEnd", {29'd0, shillings_left}, 0);
    chk("scoreboardDrained", sbQ.size(), 0);
    if (poke) begin
      sawBusy = 1'b0;
      repeat (20) begin
        @(negedge clk50);
        if (busy) sawBusy = 1'b1;
      end
      chk("noSecondSeq", {31'd0, sawBusy}, 0);
    end
    vend_req = 1'b0;
    repeat (4) @(negedge clk50);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  rises;
    int  cyc;
    bit  prevCoin;
    bit  sawDone;
    bit  sawBusy;

    reset        = 1'b0;
    vend_req     = 1'b1;
    gruel_req    = 1'b1;
    change_count = 3'd7;
    repeat (5) @(negedge clk50);
    chk("resetOutputs", {25'd0, gruel_pulse, coin_pulse, busy, done, shillings_left}, 0);

    reset   = 1'b1;
    sawBusy = 1'b0;
    repeat (20) begin
      @(negedge clk50);
      if (busy || gruel_pulse || coin_pulse) sawBusy = 1'b1;
    end
    chk("noStartAfterReset", {31'd0, sawBusy}, 0);
    vend_req  = 1'b0;
    gruel_req = 1'b0;
    repeat (5) @(negedge clk50);

    runSeq(1'b1, 3'd3, 1'b0);
    runSeq(1'b0, 3'd0, 1'b0);
    runSeq(1'b0, 3'd7, 1'b0);
    runSeq(1'b0, 3'd3, 1'b1);

    // abort during the second coin pulse: only the first coin completes
    sbQ.push_back('{1'b1, PULSE, 3});
    @(negedge clk50);
    gruel_req    = 1'b0;
    change_count = 3'd3;
    vend_req     = 1'b1;
    rises    = 0;
    cyc      = 0;
    prevCoin = 1'b0;
    sawDone  = 1'b0;
    while (rises < 2 && cyc < 200) begin
      @(negedge clk50);
      cyc++;
      if (coin_pulse && !prevCoin) rises++;
      prevCoin = coin_pulse;
      if (done) sawDone = 1'b1;
    end
    chk("reachedCoin2", rises, 2);
    #5;
    reset = 1'b0;
    #1;
    chk("abortCoin", {31'd0, coin_pulse}, 0);
    chk("abortBusy", {31'd0, busy}, 0);
    chk("abortShl", {29'd0, shillings_left}, 0);
    vend_req = 1'b0;
    repeat (5) begin
      @(negedge clk50);
      if (done) sawDone = 1'b1;
    end
    reset   = 1'b1;
    sawBusy = 1'b0;
    repeat (20) begin
      @(negedge clk50);
      if (done) sawDone = 1'b1;
      if (busy) sawBusy = 1'b1;
    end
    chk("noDoneOnAbort", {31'd0, sawDone}, 0);
    chk("noResume", {31'd0, sawBusy}, 0);
    chk("abortQueue", sbQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
